// File: rtl/pto_move_sequencer_pkg.sv
// Shared types for the PTO move sequencer: FSM states, queued command
// word layout (dir, end, stop, start = 97 bits) and command validation.
package pto_move_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2,
    ST_DWELL = 2'd3
  } state_t;

  localparam int CMD_W = 97;

  typedef struct packed {
    logic        dir;
    logic [31:0] p_end;
    logic [31:0] p_stop;
    logic [31:0] p_start;
  } cmd_t;

  // A move must have pulses and ordered ramp points.
  function automatic logic cmd_ok(input cmd_t c);
    return (c.p_end != 32'd0)
        && (c.p_start <= c.p_stop)
        && (c.p_stop <= c.p_end);
  endfunction

endpackage

// File: rtl/pto_move_sequencer_cmd_fifo.sv
// Synchronous command FIFO, show-ahead read, flush has priority.
// Ports: clk, rst (async low), push/pop/flush, wdata/rdata, full/empty/level.
module pto_move_sequencer_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 97
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pto_move_sequencer.sv
// Queues point-to-point moves and runs them one at a time on a PTO
// trapezoidal generator; tracks signed axis position from emitted pulses.
// Ports: cmd_* push side, abort/pos_clear controls, pto_* generator side,
// dir_out motor pin, status busy/move_done/aborted/timeout_err/position/queue_level.
module pto_move_sequencer
  import pto_move_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CLK_PER_US     = 50,
  parameter int unsigned DIR_SETUP_US   = 5,
  parameter int unsigned DWELL_US       = 1000,
  parameter int unsigned RUN_TIMEOUT_US = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [31:0]                   cmd_start,
  input  logic [31:0]                   cmd_stop,
  input  logic [31:0]                   cmd_end,
  input  logic                          cmd_dir,
  output logic                          cmd_err,
  input  logic                          abort,
  input  logic                          pos_clear,
  output logic                          pto_rst_n,
  output logic [31:0]                   pto_pulse_start,
  output logic [31:0]                   pto_pulse_stop,
  output logic [31:0]                   pto_pulse_end,
  input  logic                          pto_program_end,
  input  logic                          pto_in,
  output logic                          dir_out,
  output logic                          busy,
  output logic                          move_done,
  output logic                          aborted,
  output logic                          timeout_err,
  output logic [31:0]                   position,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level
);

  localparam int unsigned SU = DIR_SETUP_US * CLK_PER_US;
  localparam int unsigned DW = DWELL_US * CLK_PER_US;
  localparam int unsigned TO = RUN_TIMEOUT_US * CLK_PER_US;

  // A zero-length phase still occupies one cycle.
  localparam logic [31:0] SETUP_LAST = (SU == 0) ? 32'd0 : 32'(SU - 1);
  localparam logic [31:0] DWELL_LAST = (DW == 0) ? 32'd0 : 32'(DW - 1);
  localparam logic [31:0] TO_LAST    = (TO == 0) ? 32'd0 : 32'(TO - 1);
  localparam bit          WDOG_EN    = (RUN_TIMEOUT_US != 0);

  state_t      state;
  state_t      nstate;
  logic [31:0] timer;
  cmd_t        in_cmd;
  cmd_t        head;
  logic        full;
  logic        empty;
  logic        rdy_en;
  logic        hs;
  logic        in_ok;
  logic        pop;
  logic        flush;
  logic        tmr_clr;
  logic        done_set;
  logic        abt_set;
  logic        to_set;
  logic        pto_q;
  logic        step;

  // Keeps cmd_ready low while reset is asserted.
  assign cmd_ready = rdy_en && !full && !abort;
  assign in_cmd    = cmd_t'({cmd_dir, cmd_end, cmd_stop, cmd_start});
  assign hs        = cmd_valid && cmd_ready;
  assign in_ok     = cmd_ok(in_cmd);
  assign pto_rst_n = (state == ST_RUN);
  assign busy      = (state != ST_IDLE) || !empty;
  assign step      = pto_in && !pto_q
                  && ((state == ST_RUN) || (state == ST_DWELL));

  pto_move_sequencer_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs && in_ok),
    .pop   (pop),
    .flush (flush),
    .wdata (in_cmd),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (queue_level)
  );

  always_comb begin
    nstate   = state;
    pop      = 1'b0;
    flush    = 1'b0;
    tmr_clr  = 1'b0;
    done_set = 1'b0;
    abt_set  = 1'b0;
    to_set   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          nstate  = ST_SETUP;
          tmr_clr = 1'b1;
        end
      end
      ST_SETUP: begin
        if (timer == SETUP_LAST) begin
          nstate  = ST_RUN;
          tmr_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (pto_program_end) begin
          nstate   = ST_DWELL;
          done_set = 1'b1;
          tmr_clr  = 1'b1;
        end else if (WDOG_EN && timer == TO_LAST) begin
          nstate  = ST_DWELL;
          to_set  = 1'b1;
          flush   = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      ST_DWELL: begin
        if (timer == DWELL_LAST) begin
          nstate  = ST_IDLE;
          tmr_clr = 1'b1;
        end
      end
      default: nstate = ST_IDLE;
    endcase
    // Abort overrides everything; only a live move reports it.
    if (abort) begin
      nstate   = ST_IDLE;
      pop      = 1'b0;
      flush    = 1'b1;
      tmr_clr  = 1'b1;
      done_set = 1'b0;
      to_set   = 1'b0;
      abt_set  = (state != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_IDLE;
      timer           <= '0;
      rdy_en          <= 1'b0;
      cmd_err         <= 1'b0;
      move_done       <= 1'b0;
      aborted         <= 1'b0;
      timeout_err     <= 1'b0;
      pto_pulse_start <= '0;
      pto_pulse_stop  <= '0;
      pto_pulse_end   <= '0;
      dir_out         <= 1'b0;
    end else begin
      state       <= nstate;
      timer       <= (tmr_clr || state == ST_IDLE) ? '0 : timer + 32'd1;
      rdy_en      <= 1'b1;
      cmd_err     <= hs && !in_ok;
      move_done   <= done_set;
      aborted     <= abt_set;
      timeout_err <= timeout_err | to_set;
      if (pop) begin
        pto_pulse_start <= head.p_start;
        pto_pulse_stop  <= head.p_stop;
        pto_pulse_end   <= head.p_end;
        dir_out         <= head.dir;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pto_q    <= 1'b0;
      position <= '0;
    end else begin
      pto_q <= pto_in;
      if (pos_clear)  position <= '0;
      else if (step)  position <= dir_out ? position + 32'd1
                                          : position - 32'd1;
    end
  end

endmodule
